// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the program loader and the CPU/memory top level:
// instruction memory geometry, loader state encoding and small state-decode
// helpers used to build the registered handshake/status outputs.
// ---------------------------------------------------------------------------
package imem_loader_pkg;

  // Instruction memory geometry, shared with the CPU and the memories.
  localparam int IM_ADDR_W = 8;
  localparam int IM_DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_WRITE = 3'd4,
    S_CSUM  = 3'd5,
    S_START = 3'd6,
    S_DONE  = 3'd7
  } loaderState_e;

  // States in which the loader consumes a byte from the receiver.
  function automatic logic acceptsByte(input loaderState_e s);
    return (s == S_LEN) || (s == S_HI) || (s == S_LO) || (s == S_CSUM);
  endfunction

  // Every state except the two resting states belongs to an active load.
  function automatic logic isBusy(input loaderState_e s);
    return (s != S_IDLE) && (s != S_DONE);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
// Bundles the byte-stream handshake from the serial receiver and the
// instruction-memory write bus driven by the loader.
//   rx_data/rx_valid/rx_ready : byte stream, transfer when valid && ready
//   i_we/IM_addr/i_dataout    : instruction memory write port
// Modports:
//   master : the loader's view (drives rx_ready and the write bus)
//   slave  : the environment's view (drives the byte stream)
// ---------------------------------------------------------------------------
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IM_ADDR_W,
  parameter int DATA_W = IM_DATA_W
);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              i_we;
  logic [ADDR_W-1:0] IM_addr;
  logic [DATA_W-1:0] i_dataout;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, i_we, IM_addr, i_dataout
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, i_we, IM_addr, i_dataout
  );

endinterface

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Program-load stage ahead of the CPU. Receives a length byte followed by
// 16-bit words (high byte first), writes each word into instruction memory
// starting at START_ADDR, then pulses the CPU start input once.
// The instruction memory address mux (loader address while i_we is high,
// PC otherwise) lives in the top level, not here.
//
// Ports:
//   clock     : system clock, rising edge
//   reset     : synchronous, active-high
//   load_req  : one-cycle request to begin a load (ignored while busy)
//   bus       : imem_loader_if.master (byte stream in, memory write out)
//   start     : one-cycle CPU start pulse after a good load
//   busy      : load in progress
//   done      : last load completed successfully
//   error     : last load aborted on checksum mismatch
//
// Build option: define IMEM_LOADER_CHECKSUM_EN to expect a trailing XOR
// checksum byte over all data bytes; without it error is constant 0.
// ---------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                ADDR_W     = IM_ADDR_W,
  parameter int                DATA_W     = IM_DATA_W,
  parameter logic [ADDR_W-1:0] START_ADDR = 8'h00
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_req,
  imem_loader_if.master bus,
  output logic          start,
  output logic          busy,
  output logic          done,
  output logic          error
);

  loaderState_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [8:0]        remCount_q, remCount_d;
  logic              done_q, done_d;
  logic              rxReady_q;
  logic              we_q;
  logic              start_q;
  logic              busy_q;
  logic              byteTaken;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              error_q, error_d;
`endif

  assign byteTaken = bus.rx_valid && rxReady_q;

  // Next-state logic. A length byte of zero encodes a full 256-word image,
  // so the remaining-word counter is one bit wider than a byte. The address
  // and counter advance on the edge that leaves WRITE, which keeps IM_addr
  // and i_dataout steady for the whole write cycle.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    word_d     = word_q;
    remCount_d = remCount_q;
    done_d     = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    error_d    = error_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (load_req) begin
          state_d = S_LEN;
          addr_d  = START_ADDR;
          done_d  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = 8'h00;
          error_d = 1'b0;
`endif
        end
      end
      S_LEN: begin
        if (byteTaken) begin
          remCount_d = (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
          state_d    = S_HI;
        end
      end
      S_HI: begin
        if (byteTaken) begin
          word_d[15:8] = bus.rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d       = csum_q ^ bus.rx_data;
`endif
          state_d      = S_LO;
        end
      end
      S_LO: begin
        if (byteTaken) begin
          word_d[7:0] = bus.rx_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d      = csum_q ^ bus.rx_data;
`endif
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d     = addr_q + ADDR_W'(1);
        remCount_d = remCount_q - 9'd1;
        if (remCount_q != 9'd1) begin
          state_d = S_HI;
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_START;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (byteTaken) begin
          if (bus.rx_data == csum_q) begin
            state_d = S_START;
          end else begin
            state_d = S_DONE;
            error_d = 1'b1;
          end
        end
      end
`endif
      S_START: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers. Handshake and strobe outputs are decoded
  // from the next state so they are clean flops aligned with the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= START_ADDR;
      word_q     <= '0;
      remCount_q <= '0;
      done_q     <= 1'b0;
      rxReady_q  <= 1'b0;
      we_q       <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= 8'h00;
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      remCount_q <= remCount_d;
      done_q     <= done_d;
      rxReady_q  <= acceptsByte(state_d);
      we_q       <= (state_d == S_WRITE);
      start_q    <= (state_d == S_START);
      busy_q     <= isBusy(state_d);
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
      error_q    <= error_d;
`endif
    end
  end

  assign bus.rx_ready  = rxReady_q;
  assign bus.i_we      = we_q;
  assign bus.IM_addr   = addr_q;
  assign bus.i_dataout = word_q;
  assign start         = start_q;
  assign busy          = busy_q;
  assign done          = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign error         = error_q;
`else
  assign error         = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader. Two instances: dutA loads from
// address 00, dutB from FE to exercise address wrap. Stimulus tasks push the
// expected memory writes and start pulses into per-DUT queues; a monitor on
// the falling edge pops and compares whenever a DUT writes or pulses start.
// Honours IMEM_LOADER_CHECKSUM_EN by appending the XOR checksum byte.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_loader;
  import imem_loader_pkg::*;

  typedef struct packed {
    logic        isStart;
    logic [7:0]  addr;
    logic [15:0] data;
  } expEvent_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]  reset;
  logic [1:0]  loadReq;
  logic [1:0]  rxValid;
  logic [7:0]  rxData [2];
  logic [1:0]  rdy, we, startO, busyO, doneO, errorO;
  logic [7:0]  addrO [2];
  logic [15:0] dataO [2];

  imem_loader_if #(.ADDR_W(8), .DATA_W(16)) busA ();
  imem_loader_if #(.ADDR_W(8), .DATA_W(16)) busB ();

  assign busA.rx_valid = rxValid[0];
  assign busA.rx_data  = rxData[0];
  assign busB.rx_valid = rxValid[1];
  assign busB.rx_data  = rxData[1];
  assign rdy[0]   = busA.rx_ready;
  assign rdy[1]   = busB.rx_ready;
  assign we[0]    = busA.i_we;
  assign we[1]    = busB.i_we;
  assign addrO[0] = busA.IM_addr;
  assign addrO[1] = busB.IM_addr;
  assign dataO[0] = busA.i_dataout;
  assign dataO[1] = busB.i_dataout;

  imem_loader #(.ADDR_W(8), .DATA_W(16), .START_ADDR(8'h00)) dutA (
    .clock(clock), .reset(reset[0]), .load_req(loadReq[0]), .bus(busA),
    .start(startO[0]), .busy(busyO[0]), .done(doneO[0]), .error(errorO[0])
  );

  imem_loader #(.ADDR_W(8), .DATA_W(16), .START_ADDR(8'hFE)) dutB (
    .clock(clock), .reset(reset[1]), .load_req(loadReq[1]), .bus(busB),
    .start(startO[1]), .busy(busyO[1]), .done(doneO[1]), .error(errorO[1])
  );

  int checkCount = 0;
  int passCount  = 0;
  expEvent_t expQA[$];
  expEvent_t expQB[$];
  logic [15:0] memA [256];
  logic [1:0]  prevWe = 2'b00;
  logic [1:0]  hsEdge = 2'b00;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic failNow(input string name);
    checkCount++;
    $display("[TB] FAIL %s: got event/timeout, expected none", name);
  endtask

  task automatic pushExp(input int s, input expEvent_t e);
    if (s == 0) expQA.push_back(e);
    else        expQB.push_back(e);
  endtask

  task automatic popExp(input int s, output bit ok, output expEvent_t e);
    ok = 1'b0;
    e  = '0;
    if (s == 0) begin
      if (expQA.size() > 0) begin e = expQA.pop_front(); ok = 1'b1; end
    end else begin
      if (expQB.size() > 0) begin e = expQB.pop_front(); ok = 1'b1; end
    end
  endtask

  // Records whether a byte transfer happened on each rising edge.
  always @(posedge clock) begin
    hsEdge <= rxValid & rdy;
  end

  // Monitor: compares every write and start pulse against the scoreboard.
  task automatic monitorStep(input int s);
    expEvent_t e;
    bit ok;
    if (we[s]) begin
      checkOutput("rdyDuringWrite", rdy[s], 0);
      checkOutput("writeLatency", hsEdge[s], 1);
      if (s == 0) memA[addrO[0]] = dataO[0];
      popExp(s, ok, e);
      if (!ok) failNow("unexpectedWrite");
      else begin
        checkOutput("writeKind", we[s] & e.isStart, 0);
        checkOutput("writeAddr", addrO[s], e.addr);
        checkOutput("writeData", dataO[s], e.data);
      end
    end
    if (startO[s]) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      checkOutput("startAfterCsum", hsEdge[s], 1);
`else
      checkOutput("startAfterWrite", prevWe[s], 1);
`endif
      popExp(s, ok, e);
      if (!ok) failNow("unexpectedStart");
      else checkOutput("startKind", e.isStart, 1);
    end
  endtask

  always @(negedge clock) begin
    for (int s = 0; s < 2; s++) monitorStep(s);
    prevWe = we;
  end

  task automatic pulseLoad(input int s);
    @(negedge clock);
    loadReq[s] = 1'b1;
    rxValid[s] = 1'b0;
  endtask

  // Presents one byte until it is accepted; optional random throttling and
  // an optional load_req pulse alongside it.
  task automatic driveByte(input int s, input logic [7:0] b, input bit throttle,
                           input bit pulseReq);
    int guard = 0;
    bit sent = 1'b0;
    while (!sent) begin
      @(negedge clock);
      rxData[s]  = b;
      rxValid[s] = !throttle || ($urandom_range(0, 3) == 0);
      loadReq[s] = pulseReq && (guard == 0);
      if (rxValid[s] && rdy[s]) sent = 1'b1;
      guard++;
      if (!sent && guard > 400) begin
        failNow("byteTimeout");
        sent = 1'b1;
      end
    end
  endtask

  task automatic idleInputs(input int s);
    @(negedge clock);
    rxValid[s] = 1'b0;
    loadReq[s] = 1'b0;
  endtask

  // Issues a complete image and queues the writes and start it must cause.
  task automatic applyStimulus(input int s, input logic [15:0] words[$],
                               input logic [7:0] base, input bit throttle,
                               input bit badCsum, input int reqAtWord);
    logic [7:0] csum = 8'h00;
    expEvent_t e;
    for (int i = 0; i < words.size(); i++) begin
      e.isStart = 1'b0;
      e.addr    = base + 8'(i);
      e.data    = words[i];
      pushExp(s, e);
    end
    e = '0;
    e.isStart = 1'b1;
    if (!badCsum) pushExp(s, e);
    pulseLoad(s);
    driveByte(s, 8'(words.size()), throttle, 1'b0);
    for (int i = 0; i < words.size(); i++) begin
      driveByte(s, words[i][15:8], throttle, i == reqAtWord);
      driveByte(s, words[i][7:0], throttle, 1'b0);
      csum = csum ^ words[i][15:8] ^ words[i][7:0];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    driveByte(s, badCsum ? (csum ^ 8'h01) : csum, throttle, 1'b0);
`endif
    idleInputs(s);
  endtask

  task automatic waitIdle(input int s);
    int cyc = 0;
    while (busyO[s] && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    if (busyO[s]) failNow("idleTimeout");
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] img[$];
    reset    = 2'b11;
    loadReq  = 2'b00;
    rxValid  = 2'b00;
    rxData[0] = 8'h00;
    rxData[1] = 8'h00;
    repeat (3) @(negedge clock);

    // Reset state of both instances.
    checkOutput("rstWe", we[0], 0);
    checkOutput("rstAddrA", addrO[0], 8'h00);
    checkOutput("rstAddrB", addrO[1], 8'hFE);
    checkOutput("rstData", dataO[0], 0);
    checkOutput("rstStart", startO[0], 0);
    checkOutput("rstBusy", busyO[0], 0);
    checkOutput("rstDone", doneO[0], 0);
    checkOutput("rstError", errorO[0], 0);
    checkOutput("rstReady", rdy[0], 0);
    reset = 2'b00;
    @(negedge clock);

    // Two words, receiver always valid.
    img = {16'h1234, 16'hABCD};
    applyStimulus(0, img, 8'h00, 1'b0, 1'b0, -1);
    checkOutput("busyMidLoad", busyO[0], 1);
    waitIdle(0);
    checkOutput("done2w", doneO[0], 1);
    checkOutput("busy2w", busyO[0], 0);
    checkOutput("error2w", errorO[0], 0);

    // Throttled four-word image.
    img = {16'hDEAD, 16'hBEEF, 16'h0102, 16'hF00D};
    applyStimulus(0, img, 8'h00, 1'b1, 1'b0, -1);
    waitIdle(0);
    checkOutput("doneThr", doneO[0], 1);
    for (int i = 0; i < 4; i++) checkOutput("memThr", memA[i], img[i]);

    // Abort after the high byte of word 2.
    begin
      expEvent_t e;
      e = '0;
      e.addr = 8'h00;
      e.data = 16'hAAAA;
      pushExp(0, e);
      pulseLoad(0);
      driveByte(0, 8'h03, 1'b0, 1'b0);
      driveByte(0, 8'hAA, 1'b0, 1'b0);
      driveByte(0, 8'hAA, 1'b0, 1'b0);
      driveByte(0, 8'h55, 1'b0, 1'b0);
      @(negedge clock);
      rxValid[0] = 1'b0;
      checkOutput("busyBeforeAbort", busyO[0], 1);
      reset[0] = 1'b1;
      @(negedge clock);
      reset[0] = 1'b0;
      checkOutput("abortBusy", busyO[0], 0);
      checkOutput("abortDone", doneO[0], 0);
      checkOutput("abortAddr", addrO[0], 8'h00);
      checkOutput("abortPending", expQA.size(), 0);
      checkOutput("abortMem0", memA[0], 16'hAAAA);
      checkOutput("abortMem1", memA[1], 16'hBEEF);
      repeat (4) @(negedge clock);
    end

    // Fresh load after the abort overwrites word 0.
    img = {16'h9999};
    applyStimulus(0, img, 8'h00, 1'b0, 1'b0, -1);
    waitIdle(0);
    checkOutput("freshMem0", memA[0], 16'h9999);
    checkOutput("freshDone", doneO[0], 1);

    // load_req during a load must not restart it.
    img = {16'h0A0B, 16'h0C0D};
    applyStimulus(0, img, 8'h00, 1'b0, 1'b0, 0);
    waitIdle(0);
    checkOutput("busyReqDone", doneO[0], 1);
    checkOutput("busyReqMem1", memA[1], 16'h0C0D);

    // Address wrap on the FE-based instance.
    img = {16'h0001, 16'h0002, 16'h0003};
    applyStimulus(1, img, 8'hFE, 1'b0, 1'b0, -1);
    waitIdle(1);
    checkOutput("wrapDone", doneO[1], 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    img = {16'h1234};
    applyStimulus(0, img, 8'h00, 1'b0, 1'b0, -1);
    waitIdle(0);
    checkOutput("csumGoodDone", doneO[0], 1);
    checkOutput("csumGoodErr", errorO[0], 0);
    applyStimulus(0, img, 8'h00, 1'b0, 1'b1, -1);
    waitIdle(0);
    checkOutput("csumBadDone", doneO[0], 0);
    checkOutput("csumBadErr", errorO[0], 1);
`endif

    repeat (3) @(negedge clock);
    checkOutput("pendingA", expQA.size(), 0);
    checkOutput("pendingB", expQB.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
